// File: rtl/hacd_pkg.sv
// Shared types and default widths for the hawk lookup scheduler.
package hacd_pkg;

  localparam int unsigned HAWK_ADDR_W = 40;
  localparam int unsigned HAWK_PPA_W  = 40;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOOKUP  = 3'd2,
    ST_TBL_UPD = 3'd3,
    ST_GRANT   = 3'd4
  } lkup_sched_state_t;

  typedef enum logic {
    SIDE_RD = 1'b0,
    SIDE_WR = 1'b1
  } lkup_side_e;

endpackage

// File: rtl/hawk_rr_arb2.sv
// Combinational 2-way round-robin picker. req[0] is the read side,
// req[1] the write side; on a tie the side not served last wins.
module hawk_rr_arb2
  import hacd_pkg::*;
(
  input  logic [1:0] req,
  input  lkup_side_e last_side,
  output lkup_side_e gnt_side,
  output logic       any
);

  // Pick the winner from the pending requests and the last-served side
  always_comb begin
    any      = |req;
    gnt_side = SIDE_RD;
    if (req == 2'b11) begin
      gnt_side = (last_side == SIDE_RD) ? SIDE_WR : SIDE_RD;
    end else if (req[1]) begin
      gnt_side = SIDE_WR;
    end
  end

endmodule

// File: rtl/hawk_lkup_sched.sv
// Lookup/translation sequencer: shares the page-read-manager lookup port
// between CPU read and write streams and returns a one-cycle grant with the
// translated PPA. Optional lookup watchdog enabled by HAWK_LKUP_WDOG_EN.
module hawk_lkup_sched
  import hacd_pkg::*;
#(
  parameter int unsigned ADDR_W = HAWK_ADDR_W,
  parameter int unsigned PPA_W  = HAWK_PPA_W,
  parameter int unsigned WDOG_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_done,
  input  logic              rd_req_valid,
  input  logic [ADDR_W-1:0] rd_req_hppa,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_hppa,
  output logic              rd_gnt,
  output logic              wr_gnt,
  output logic [PPA_W-1:0]  gnt_ppa,
  input  logic              lkup_ready,
  output logic              lkup_valid,
  output logic [ADDR_W-1:0] lkup_hppa,
  input  logic              trnsl_allow,
  input  logic              trnsl_tbl_update,
  input  logic [PPA_W-1:0]  trnsl_ppa,
  input  logic              tbl_update_done,
  output logic              busy,
  output logic              wdog_err
);

  lkup_sched_state_t state_q, state_d;
  lkup_side_e        side_q, last_q, arb_side;
  logic              arb_any;
  logic              arb_take;
  logic              wdog_abort;

  hawk_rr_arb2 u_arb (
    .req       ({wr_req_valid, rd_req_valid}),
    .last_side (last_q),
    .gnt_side  (arb_side),
    .any       (arb_any)
  );

  // Next-state selection; a watchdog abort overrides any pending response
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:    if (init_done) state_d = ST_IDLE;
      ST_IDLE:    if (lkup_ready && arb_any) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (trnsl_allow)           state_d = ST_GRANT;
        else if (trnsl_tbl_update) state_d = ST_TBL_UPD;
      end
      ST_TBL_UPD: if (tbl_update_done) state_d = ST_GRANT;
      ST_GRANT:   state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
    if (wdog_abort) state_d = ST_IDLE;
  end

  assign arb_take = (state_q == ST_IDLE) && (state_d == ST_LOOKUP);

  // State and control outputs, all registered from the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      lkup_valid <= 1'b0;
      busy       <= 1'b0;
      rd_gnt     <= 1'b0;
      wr_gnt     <= 1'b0;
      last_q     <= SIDE_WR;
    end else begin
      state_q    <= state_d;
      lkup_valid <= (state_d == ST_LOOKUP);
      busy       <= (state_d != ST_IDLE) && (state_d != ST_INIT);
      rd_gnt     <= (state_d == ST_GRANT) && (side_q == SIDE_RD);
      wr_gnt     <= (state_d == ST_GRANT) && (side_q == SIDE_WR);
      // An aborted side counts as served so the other side goes next
      if ((state_q == ST_GRANT) || wdog_abort) last_q <= side_q;
    end
  end

  // Datapath latches: winner side/address in IDLE, translated PPA in LOOKUP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      side_q    <= SIDE_RD;
      lkup_hppa <= '0;
      gnt_ppa   <= '0;
    end else begin
      if (arb_take) begin
        side_q    <= arb_side;
        lkup_hppa <= (arb_side == SIDE_WR) ? wr_req_hppa : rd_req_hppa;
      end
      if ((state_q == ST_LOOKUP) &&
          ((state_d == ST_GRANT) || (state_d == ST_TBL_UPD))) begin
        gnt_ppa <= trnsl_ppa;
      end
    end
  end

`ifdef HAWK_LKUP_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q;

  assign wdog_abort = ((state_q == ST_LOOKUP) || (state_q == ST_TBL_UPD)) &&
                      (wdog_cnt_q == '1);

  // Count cycles spent in flight; restart on each entry to LOOKUP/TBL_UPD
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q <= '0;
      wdog_err   <= 1'b0;
    end else begin
      if ((state_d != state_q) &&
          ((state_d == ST_LOOKUP) || (state_d == ST_TBL_UPD))) begin
        wdog_cnt_q <= '0;
      end else if ((state_q == ST_LOOKUP) || (state_q == ST_TBL_UPD)) begin
        wdog_cnt_q <= wdog_cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
      end
      if (wdog_abort) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_abort = 1'b0;
  // Without the watchdog WDOG_W sizes nothing; the flag stays low
  assign wdog_err   = (WDOG_W != 0) && 1'b0;
`endif

endmodule

// File: tb/tb_hawk_lkup_sched.sv
// Self-checking bench for hawk_lkup_sched: directed vector table, hand
// sequences for init/reset/watchdog, and random transactions against a
// transaction-level reference model.
module tb_hawk_lkup_sched;

  localparam int unsigned AW = 40;
  localparam int unsigned PW = 40;
  localparam int unsigned WW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          init_done;
  logic          rd_req_valid, wr_req_valid;
  logic [AW-1:0] rd_req_hppa, wr_req_hppa, lkup_hppa;
  logic          rd_gnt, wr_gnt;
  logic [PW-1:0] gnt_ppa, trnsl_ppa;
  logic          lkup_ready, lkup_valid;
  logic          trnsl_allow, trnsl_tbl_update, tbl_update_done;
  logic          busy, wdog_err;

  int checks = 0;
  int errors = 0;
  logic last_wr_m;

  typedef struct {
    logic          rd_v;
    logic          wr_v;
    logic [AW-1:0] rd_hppa;
    logic [AW-1:0] wr_hppa;
    int unsigned   stall;
    int unsigned   resp;     // 0 allow, 1 table update, 2 both together
    int unsigned   dly;
    int unsigned   ddly;
    logic [PW-1:0] ppa;
    logic          drop;
    logic          exp_wr;
    logic [AW-1:0] exp_hppa;
    int unsigned   exp_lat;
  } vec_t;

  vec_t tbl[9];

  always #5 clk_i = ~clk_i;

  hawk_lkup_sched #(.ADDR_W(AW), .PPA_W(PW), .WDOG_W(WW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .init_done        (init_done),
    .rd_req_valid     (rd_req_valid),
    .rd_req_hppa      (rd_req_hppa),
    .wr_req_valid     (wr_req_valid),
    .wr_req_hppa      (wr_req_hppa),
    .rd_gnt           (rd_gnt),
    .wr_gnt           (wr_gnt),
    .gnt_ppa          (gnt_ppa),
    .lkup_ready       (lkup_ready),
    .lkup_valid       (lkup_valid),
    .lkup_hppa        (lkup_hppa),
    .trnsl_allow      (trnsl_allow),
    .trnsl_tbl_update (trnsl_tbl_update),
    .trnsl_ppa        (trnsl_ppa),
    .tbl_update_done  (tbl_update_done),
    .busy             (busy),
    .wdog_err         (wdog_err)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rd_req_valid     = 1'b0;
    wr_req_valid     = 1'b0;
    rd_req_hppa      = '0;
    wr_req_hppa      = '0;
    lkup_ready       = 1'b0;
    trnsl_allow      = 1'b0;
    trnsl_tbl_update = 1'b0;
    trnsl_ppa        = '0;
    tbl_update_done  = 1'b0;
  endtask

  task automatic do_reset(input logic init);
    rst_ni = 1'b0;
    clear_inputs();
    init_done = init;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();
    last_wr_m = 1'b1;
  endtask

  function automatic vec_t mk(input logic rv, input logic wv,
                              input logic [AW-1:0] rh, input logic [AW-1:0] wh,
                              input int unsigned stall, input int unsigned resp,
                              input int unsigned dly, input int unsigned ddly,
                              input logic [PW-1:0] ppa, input logic drop,
                              input logic exp_wr, input int unsigned exp_lat);
    vec_t v;
    v.rd_v = rv;  v.wr_v = wv;  v.rd_hppa = rh;  v.wr_hppa = wh;
    v.stall = stall;  v.resp = resp;  v.dly = dly;  v.ddly = ddly;
    v.ppa = ppa;  v.drop = drop;  v.exp_wr = exp_wr;
    v.exp_hppa = exp_wr ? wh : rh;
    v.exp_lat = exp_lat;
    return v;
  endfunction

  // Reference model: round-robin winner and grant latency from the rules
  function automatic vec_t predict(input vec_t v, input logic last_wr);
    vec_t r = v;
    if (v.rd_v && v.wr_v) r.exp_wr = ~last_wr;
    else                  r.exp_wr = v.wr_v;
    r.exp_hppa = r.exp_wr ? v.wr_hppa : v.rd_hppa;
    r.exp_lat  = (v.resp == 1) ? 3 + v.dly + v.ddly : 2 + v.dly;
    return r;
  endfunction

  // One full transaction from request in IDLE to the IDLE after the grant
  task automatic run_txn(input vec_t v);
    int unsigned lat;
    rd_req_valid = v.rd_v;
    wr_req_valid = v.wr_v;
    rd_req_hppa  = v.rd_hppa;
    wr_req_hppa  = v.wr_hppa;
    lkup_ready   = 1'b0;
    for (int unsigned i = 0; i < v.stall; i++) begin
      tick();
      chk("stall_no_lookup", lkup_valid, 0);
    end
    lkup_ready = 1'b1;
    tick();
    lat = 1;
    chk("lookup_valid", lkup_valid, 1);
    chk("lookup_hppa", lkup_hppa, v.exp_hppa);
    chk("busy_in_lookup", busy, 1);
    if (v.drop) begin
      rd_req_valid = 1'b0;
      wr_req_valid = 1'b0;
    end
    for (int unsigned i = 0; i < v.dly; i++) begin
      tbl_update_done = 1'($urandom_range(0, 1));
      trnsl_ppa = PW'({$urandom(), $urandom()});
      tick();
      lat++;
      chk("lookup_held", lkup_valid, 1);
      chk("no_early_gnt", {rd_gnt, wr_gnt}, 0);
    end
    tbl_update_done  = 1'b0;
    trnsl_allow      = (v.resp != 1);
    trnsl_tbl_update = (v.resp != 0);
    trnsl_ppa        = v.ppa;
    tick();
    lat++;
    trnsl_allow      = 1'b0;
    trnsl_tbl_update = 1'b0;
    trnsl_ppa        = PW'({$urandom(), $urandom()});
    if (v.resp == 1) begin
      chk("tbl_upd_lookup_low", lkup_valid, 0);
      chk("tbl_upd_no_gnt", {rd_gnt, wr_gnt}, 0);
      for (int unsigned i = 0; i < v.ddly; i++) begin
        tick();
        lat++;
        chk("tbl_upd_wait_gnt", {rd_gnt, wr_gnt}, 0);
      end
      tbl_update_done = 1'b1;
      tick();
      lat++;
      tbl_update_done = 1'b0;
    end
    chk("gnt_side", {rd_gnt, wr_gnt}, v.exp_wr ? 2'b01 : 2'b10);
    chk("gnt_ppa", gnt_ppa, v.ppa);
    chk("gnt_latency", lat, v.exp_lat);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    tick();
    chk("gnt_one_cycle", {rd_gnt, wr_gnt}, 0);
    chk("idle_after_gnt", {busy, lkup_valid}, 0);
    last_wr_m = v.exp_wr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk(1, 0, 40'hA0_0000_0001, 40'h0,           0, 0, 0, 0, 40'h11,          0, 0, 2);
    tbl[1] = mk(0, 1, 40'h0,            40'h1234,        0, 1, 0, 9, 40'h55,          0, 1, 12);
    tbl[2] = mk(1, 1, 40'h100,          40'h200,         0, 0, 1, 0, 40'hFF_FFFF_FFFF, 0, 0, 3);
    tbl[3] = mk(1, 1, 40'h300,          40'h400,         0, 2, 0, 0, 40'h77,          0, 1, 2);
    tbl[4] = mk(1, 1, 40'h500,          40'h600,         0, 1, 2, 0, 40'h0,           0, 0, 5);
    tbl[5] = mk(1, 0, 40'h700,          40'h0,           3, 0, 0, 0, 40'h123,         0, 0, 2);
    tbl[6] = mk(1, 1, 40'h800,          40'h900,         0, 0, 0, 0, 40'h456,         1, 1, 2);
    tbl[7] = mk(0, 1, 40'h0,            40'hFF_FFFF_FFFF, 0, 2, 3, 0, 40'hABC,         0, 1, 5);
    tbl[8] = mk(1, 1, 40'hA00,          40'hB00,         2, 0, 0, 0, 40'hDEAD,        0, 0, 2);

    // Reset values with initialisation still pending
    do_reset(1'b0);
    chk("rst_lkup_valid", lkup_valid, 0);
    chk("rst_lkup_hppa", lkup_hppa, 0);
    chk("rst_gnt", {rd_gnt, wr_gnt}, 0);
    chk("rst_gnt_ppa", gnt_ppa, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wdog_err", wdog_err, 0);

    // Requests ignored until init_done
    rd_req_valid = 1'b1;
    rd_req_hppa  = 40'hBEEF;
    lkup_ready   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("init_hold_lookup", lkup_valid, 0);
      chk("init_hold_busy", busy, 0);
    end
    init_done = 1'b1;
    tick();
    chk("init_exit_lookup", lkup_valid, 0);
    run_txn(mk(1, 0, 40'hBEEF, 40'h0, 0, 0, 0, 0, 40'h42, 0, 0, 2));

    // Directed vector table from a fresh reset
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Both sides pending continuously: strict alternation starting with read
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      run_txn(mk(1, 1, AW'(40'h1000 + k), AW'(40'h2000 + k), 0, 0, 0, 0,
                 PW'(40'h300 + k), 0, (k % 2 == 1), 2));
    end

    // Asynchronous reset in the middle of LOOKUP
    do_reset(1'b1);
    rd_req_valid = 1'b1;
    rd_req_hppa  = 40'hCAFE;
    lkup_ready   = 1'b1;
    tick();
    chk("midrst_lookup_up", lkup_valid, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_lookup", {lkup_valid, lkup_hppa}, 0);
    chk("midrst_gnt", {rd_gnt, wr_gnt, gnt_ppa}, 0);
    chk("midrst_busy", {busy, wdog_err}, 0);
    trnsl_allow = 1'b1;
    trnsl_ppa   = 40'h99;
    tick();
    chk("midrst_no_gnt", {rd_gnt, wr_gnt}, 0);
    #2 rst_ni = 1'b1;
    clear_inputs();
    tick();
    chk("midrst_after_gnt", {rd_gnt, wr_gnt, lkup_valid}, 0);

    // Random transactions against the reference model
    do_reset(1'b1);
    for (int n = 0; n < 150; n++) begin
      vec_t v;
      v.rd_v    = 1'($urandom_range(0, 1));
      v.wr_v    = v.rd_v ? 1'($urandom_range(0, 1)) : 1'b1;
      v.rd_hppa = AW'({$urandom(), $urandom()});
      v.wr_hppa = AW'({$urandom(), $urandom()});
      v.stall   = $urandom_range(0, 2);
      v.resp    = $urandom_range(0, 2);
      v.dly     = $urandom_range(0, 4);
      v.ddly    = $urandom_range(0, 6);
      v.ppa     = PW'({$urandom(), $urandom()});
      v.drop    = 1'($urandom_range(0, 1));
      run_txn(predict(v, last_wr_m));
    end

`ifdef HAWK_LKUP_WDOG_EN
    // Lookup that never gets a translation response
    begin
      int n;
      do_reset(1'b1);
      rd_req_valid = 1'b1;
      rd_req_hppa  = 40'h5A5A;
      lkup_ready   = 1'b1;
      tick();
      n = 1;
      chk("wdog_lookup_up", lkup_valid, 1);
      for (int i = 0; i < 40; i++) begin
        tick();
        chk("wdog_no_gnt", {rd_gnt, wr_gnt}, 0);
        if (!lkup_valid) break;
        n++;
      end
      chk("wdog_lookup_len", n, 16);
      chk("wdog_err_set", wdog_err, 1);
      chk("wdog_idle", busy, 0);
      rd_req_valid = 1'b0;
      run_txn(mk(1, 1, 40'h11, 40'h22, 0, 0, 0, 0, 40'h33, 0, 1, 2));
      chk("wdog_err_sticky", wdog_err, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
